// File: rtl/multichannel_fifo_ctrl_if.sv
// Shared write/read/flush/status bus for multichannel_fifo_ctrl.
// The producer/consumer side uses the master modport, the controller the slave.
interface multichannel_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 256,
  parameter int NUM_CH     = 4
);
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [CH_W-1:0]       rd_ch;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  flush_en;
  logic [CH_W-1:0]       flush_ch;
  logic                  status_clr;
  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     empty;
  logic [NUM_CH-1:0]     almost_full;
  logic [NUM_CH-1:0]     almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic [7:0]            status;

  modport master (
    output wr_en, wr_ch, wr_data, rd_en, rd_ch, flush_en, flush_ch, status_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, level, status
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, rd_en, rd_ch, flush_en, flush_ch, status_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, level, status
  );
endinterface

// File: rtl/multichannel_fifo_ctrl.sv
// N-channel FIFO controller: shared write and read ports with channel select,
// per-channel pointers/counts/flags, per-channel flush, sticky overflow and
// underflow capture, packed status byte.
// Optional build macro FIFO_CTRL_FWFT_EN selects first-word-fall-through reads
// (combinational rd_data/rd_valid); undefined gives registered read data.
module multichannel_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 256,
  parameter int NUM_CH     = 4,
  parameter int AF_THRESH  = FIFO_DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input logic                     clk,
  input logic                     rst,
  multichannel_fifo_ctrl_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned NCH = NUM_CH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_AE   = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  logic [DATA_WIDTH-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr [NUM_CH];
  logic [ADDR_WIDTH-1:0] rd_ptr [NUM_CH];
  logic [ADDR_WIDTH:0]   cnt    [NUM_CH];

  logic [NUM_CH-1:0] full_v, empty_v, af_v, ae_v;
  logic [NUM_CH-1:0] wr_sel, rd_sel, fl_sel;
  logic wr_in, rd_in, fl_in;
  logic wr_acc, rd_acc, wr_hit_fl, rd_hit_fl, wr_do, rd_do, ovf, udf;
  logic ovf_st, udf_st;
  logic [3:0] err_ch;
  logic [DATA_WIDTH-1:0] head;
  logic [ADDR_WIDTH:0]   rd_cnt;

  // Per-channel flags straight from the registered counts.
  always_comb begin
    full_v  = '0;
    empty_v = '0;
    af_v    = '0;
    ae_v    = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      full_v[c]  = (cnt[c] == CNT_FULL);
      empty_v[c] = (cnt[c] == '0);
      af_v[c]    = (cnt[c] >= CNT_AF);
      ae_v[c]    = (cnt[c] <= CNT_AE);
    end
  end

  // Acceptance, flush priority and error detection for the shared ports.
  always_comb begin
    wr_in = (32'(bus.wr_ch)    < NCH);
    rd_in = (32'(bus.rd_ch)    < NCH);
    fl_in = bus.flush_en && (32'(bus.flush_ch) < NCH);
    head   = '0;
    rd_cnt = '0;
    if (rd_in) begin
      head   = mem[bus.rd_ch][rd_ptr[bus.rd_ch]];
      rd_cnt = cnt[bus.rd_ch];
    end
    rd_acc = bus.rd_en && rd_in && !empty_v[bus.rd_ch];
    // A full channel still takes a write when the same channel pops this cycle.
    wr_acc = bus.wr_en && wr_in &&
             (!full_v[bus.wr_ch] || (rd_acc && (bus.rd_ch == bus.wr_ch)));
    wr_hit_fl = fl_in && (bus.flush_ch == bus.wr_ch);
    rd_hit_fl = fl_in && (bus.flush_ch == bus.rd_ch);
    wr_do = wr_acc && !wr_hit_fl;
    rd_do = rd_acc && !rd_hit_fl;
    // Accesses swallowed by a flush are silent, not errors.
    ovf = bus.wr_en && !wr_acc && !wr_hit_fl;
    udf = bus.rd_en && !rd_acc && !rd_hit_fl;
    wr_sel = '0;
    rd_sel = '0;
    fl_sel = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      wr_sel[c] = wr_do && (bus.wr_ch    == CH_W'(c));
      rd_sel[c] = rd_do && (bus.rd_ch    == CH_W'(c));
      fl_sel[c] = fl_in && (bus.flush_ch == CH_W'(c));
    end
  end

  // Per-channel pointers and occupancy; flush clears the channel outright.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (rst || fl_sel[c]) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end else begin
        if (wr_sel[c]) wr_ptr[c] <= wr_ptr[c] + PTR_ONE;
        if (rd_sel[c]) rd_ptr[c] <= rd_ptr[c] + PTR_ONE;
        if (wr_sel[c] && !rd_sel[c])      cnt[c] <= cnt[c] + CNT_ONE;
        else if (!wr_sel[c] && rd_sel[c]) cnt[c] <= cnt[c] - CNT_ONE;
      end
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_do) mem[bus.wr_ch][wr_ptr[bus.wr_ch]] <= bus.wr_data;
  end

  // Sticky error capture; a fresh error outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_st <= 1'b0;
      udf_st <= 1'b0;
      err_ch <= '0;
    end else begin
      ovf_st <= (ovf_st && !bus.status_clr) || ovf;
      udf_st <= (udf_st && !bus.status_clr) || udf;
      if (ovf)                 err_ch <= 4'(bus.wr_ch);
      else if (udf)            err_ch <= 4'(bus.rd_ch);
      else if (bus.status_clr) err_ch <= '0;
    end
  end

`ifdef FIFO_CTRL_FWFT_EN
  // Head word presented combinationally; rd_en just pops it at the edge.
  always_comb begin
    bus.rd_data  = head;
    bus.rd_valid = rd_in && !empty_v[bus.rd_ch];
  end
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  // Registered read data; rd_data holds its last value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_do;
      if (rd_do) rd_data_q <= head;
    end
  end

  always_comb begin
    bus.rd_data  = rd_data_q;
    bus.rd_valid = rd_valid_q;
  end
`endif

  // Flag, level and status outputs.
  always_comb begin
    bus.full         = full_v;
    bus.empty        = empty_v;
    bus.almost_full  = af_v;
    bus.almost_empty = ae_v;
    bus.level        = rd_cnt;
    bus.status       = {err_ch, &empty_v, |full_v, udf_st, ovf_st};
  end
endmodule

// File: tb/tb_multichannel_fifo_ctrl.sv
// Directed self-checking bench for multichannel_fifo_ctrl (default parameters:
// 32-bit words, 256 deep, 4 channels, thresholds 252/4).
module tb_multichannel_fifo_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp;
  int   n_bad;

  multichannel_fifo_ctrl_if #(.DATA_WIDTH(32), .FIFO_DEPTH(256), .NUM_CH(4)) bus ();

  multichannel_fifo_ctrl #(
    .DATA_WIDTH(32), .FIFO_DEPTH(256), .NUM_CH(4), .AF_THRESH(252), .AE_THRESH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_ch = '0;
    bus.flush_en = 1'b0; bus.flush_ch = '0; bus.status_clr = 1'b0;
  endtask

  // One read of channel ch expecting word exp; other inputs left as set by caller.
  task automatic rd_step(input logic [1:0] ch, input logic [31:0] exp, input string tag);
    bus.rd_en = 1'b1;
    bus.rd_ch = ch;
`ifdef FIFO_CTRL_FWFT_EN
    #1;
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check(tag, bus.rd_data, exp);
    tick();
`else
    tick();
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check(tag, bus.rd_data, exp);
`endif
    bus.rd_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_empty",  32'(bus.empty), 32'hF);
    check("rst_full",   32'(bus.full), 32'h0);
    check("rst_ae",     32'(bus.almost_empty), 32'hF);
    check("rst_af",     32'(bus.almost_full), 32'h0);
    check("rst_valid",  32'(bus.rd_valid), 32'd0);
    check("rst_level",  32'(bus.level), 32'd0);
    check("rst_status", 32'(bus.status), 32'h08);
`ifndef FIFO_CTRL_FWFT_EN
    check("rst_rdata",  bus.rd_data, 32'h0);
`endif
    rst = 1'b0;

    // Basic write/read order on channel 2
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1; bus.wr_ch = 2'd2; bus.wr_data = 32'hA0 + 32'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.rd_ch = 2'd2;
    #1;
    check("c2_level4", 32'(bus.level), 32'd4);
    check("c2_empty",  32'(bus.empty), 32'hB);
    for (int i = 0; i < 4; i++) rd_step(2'd2, 32'hA0 + 32'(i), "c2_rd");
    tick();
`ifndef FIFO_CTRL_FWFT_EN
    check("c2_idle_valid", 32'(bus.rd_valid), 32'd0);
    check("c2_hold_data",  bus.rd_data, 32'hA3);
`endif
    check("c2_empty_after", 32'(bus.empty), 32'hF);
    check("c2_status",      32'(bus.status), 32'h08);

    // Fill channel 0, then overflow
    for (int i = 0; i < 256; i++) begin
      bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_data = 32'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.rd_ch = 2'd0;
    #1;
    check("c0_level_full", 32'(bus.level), 32'd256);
    check("c0_full",       32'(bus.full), 32'h1);
    check("c0_af",         32'(bus.almost_full), 32'h1);
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_data = 32'hDEAD;
    tick();
    bus.wr_en = 1'b0;
    check("ovf_status", 32'(bus.status), 32'h05);
    check("ovf_level",  32'(bus.level), 32'd256);
    bus.status_clr = 1'b1;
    tick();
    bus.status_clr = 1'b0;
    check("ovf_clr_status", 32'(bus.status), 32'h04);
    bus.flush_en = 1'b1; bus.flush_ch = 2'd0;
    tick();
    bus.flush_en = 1'b0;
    check("c0_flush_empty",  32'(bus.empty), 32'hF);
    check("c0_flush_status", 32'(bus.status), 32'h08);

    // Full channel 1: simultaneous write and read
    for (int i = 0; i < 256; i++) begin
      bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_data = 32'h100 + 32'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    check("c1_full", 32'(bus.full), 32'h2);
    bus.wr_en = 1'b1; bus.wr_ch = 2'd1; bus.wr_data = 32'h55;
    rd_step(2'd1, 32'h100, "c1_simul");
    bus.wr_en = 1'b0;
    check("c1_simul_status", 32'(bus.status), 32'h04);
    check("c1_simul_level",  32'(bus.level), 32'd256);
    for (int i = 0; i < 255; i++) rd_step(2'd1, 32'h101 + 32'(i), "c1_drain");
    rd_step(2'd1, 32'h55, "c1_last");
    check("c1_empty_after", 32'(bus.empty), 32'hF);
    check("c1_status",      32'(bus.status), 32'h08);

    // Underflow on channel 3 while writing it
    bus.wr_en = 1'b1; bus.wr_ch = 2'd3; bus.wr_data = 32'h33;
    bus.rd_en = 1'b1; bus.rd_ch = 2'd3;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    check("udf_status", 32'(bus.status), 32'h32);
    check("udf_level",  32'(bus.level), 32'd1);
`ifndef FIFO_CTRL_FWFT_EN
    check("udf_valid",  32'(bus.rd_valid), 32'd0);
`endif
    bus.status_clr = 1'b1;
    tick();
    bus.status_clr = 1'b0;
    check("udf_clr_status", 32'(bus.status), 32'h00);
    bus.flush_en = 1'b1; bus.flush_ch = 2'd3;
    tick();
    bus.flush_en = 1'b0;
    check("c3_flush_status", 32'(bus.status), 32'h08);

    // Flush channel 0 against a same-cycle write, read channel 1 alongside
    for (int i = 0; i < 10; i++) begin
      bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_data = 32'hC0 + 32'(i);
      tick();
    end
    bus.wr_ch = 2'd1; bus.wr_data = 32'h77;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_ch = 2'd0;
    #1;
    check("fl_pre_level", 32'(bus.level), 32'd10);
    bus.flush_en = 1'b1; bus.flush_ch = 2'd0;
    bus.wr_en = 1'b1; bus.wr_ch = 2'd0; bus.wr_data = 32'hEE;
    rd_step(2'd1, 32'h77, "fl_rd_c1");
    idle();
    #1;
    check("fl_empty",  32'(bus.empty), 32'hF);
    check("fl_status", 32'(bus.status), 32'h08);
    check("fl_level0", 32'(bus.level), 32'd0);

    // 300 words through channel 2 with pointer wrap and threshold crossings
    for (int i = 0; i < 254; i++) begin
      bus.wr_en = 1'b1; bus.wr_ch = 2'd2; bus.wr_data = 32'(i);
      tick();
      check("st_af_fill", 32'(bus.almost_full[2]),  32'((i + 1) >= 252));
      check("st_ae_fill", 32'(bus.almost_empty[2]), 32'((i + 1) <= 4));
    end
    for (int k = 0; k < 46; k++) begin
      bus.wr_en = 1'b1; bus.wr_ch = 2'd2; bus.wr_data = 32'(254 + k);
      rd_step(2'd2, 32'(k), "st_stream");
    end
    bus.wr_en = 1'b0;
    check("st_stream_level", 32'(bus.level), 32'd254);
    for (int k = 46; k < 300; k++) begin
      rd_step(2'd2, 32'(k), "st_drain");
      check("st_af_drain", 32'(bus.almost_full[2]),  32'((299 - k) >= 252));
      check("st_ae_drain", 32'(bus.almost_empty[2]), 32'((299 - k) <= 4));
    end
    check("st_empty",  32'(bus.empty), 32'hF);
    check("st_status", 32'(bus.status), 32'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
